// File: rtl/score_leaderboard_if.sv
// Submission / completion / rank-read bundle for score_leaderboard.
// master: the side issuing submissions and reads; slave: the leaderboard.
interface score_leaderboard_if #(
    parameter int N_ENTRIES    = 8,
    parameter int ID_DIGITS    = 4,
    parameter int SCORE_DIGITS = 2
);
    localparam int RANK_W = $clog2(N_ENTRIES);

    logic                      submit;
    logic                      is_guest;
    logic [4*ID_DIGITS-1:0]    sub_id;
    logic [4*SCORE_DIGITS-1:0] sub_score;
    logic                      clear;
    logic                      busy;
    logic                      done;
    logic                      inserted;
    logic [RANK_W-1:0]         ins_rank;
    logic [RANK_W-1:0]         rank_sel;
    logic                      rank_valid;
    logic [4*ID_DIGITS-1:0]    rank_id;
    logic [4*SCORE_DIGITS-1:0] rank_score;

    modport master (
        output submit, is_guest, sub_id, sub_score, clear, rank_sel,
        input  busy, done, inserted, ins_rank, rank_valid, rank_id, rank_score
    );

    modport slave (
        input  submit, is_guest, sub_id, sub_score, clear, rank_sel,
        output busy, done, inserted, ins_rank, rank_valid, rank_id, rank_score
    );
endinterface

// File: rtl/score_leaderboard.sv
// Sorted top-N (player ID, BCD score) table. One submission at a time:
// CHECK validates BCD, SCAN finds the insertion rank (ties rank below),
// SHIFT pushes lower entries down one slot per cycle, WRITE places the entry.
// Completion is always at a fixed edge per outcome, independent of rank.
// Optional build macro SCORE_LEADERBOARD_GUEST_FILTER_EN rejects guest
// submissions in CHECK.
module score_leaderboard #(
    parameter int N_ENTRIES    = 8,
    parameter int ID_DIGITS    = 4,
    parameter int SCORE_DIGITS = 2
) (
    input logic                clk,
    input logic                rst,
    score_leaderboard_if.slave bus
);
    localparam int RANK_W   = $clog2(N_ENTRIES);
    localparam int ID_W     = 4 * ID_DIGITS;
    localparam int SC_W     = 4 * SCORE_DIGITS;
    localparam int RD_DEPTH = 1 << RANK_W;
    localparam logic [RANK_W-1:0] LAST = RANK_W'(N_ENTRIES - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, SHIFT, WRITE, DONE} state_t;
    state_t state, nextState;

    logic [N_ENTRIES-1:0]           slotValid;
    logic [N_ENTRIES-1:0][ID_W-1:0] slotId;
    logic [N_ENTRIES-1:0][SC_W-1:0] slotScore;

    logic [ID_W-1:0]   newId;
    logic [SC_W-1:0]   newScore;
    logic [RANK_W-1:0] scanIdx;
    logic [RANK_W-1:0] shiftIdx;
    logic [RANK_W-1:0] hitIdx;
    logic              insFlag;
    logic              hit;
    logic              guestReject;

    logic              busyC, doneC, insertedC;
    logic [RANK_W-1:0] insRankC;

    // True when every nibble is a legal BCD digit.
    function automatic logic isBcd(input logic [ID_W+SC_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < (ID_W + SC_W) / 4; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

`ifdef SCORE_LEADERBOARD_GUEST_FILTER_EN
    logic newGuest;

    // Guest flag is captured with the submission so CHECK sees a stable value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          newGuest <= 1'b0;
        else if (state == IDLE && !bus.clear && bus.submit) newGuest <= bus.is_guest;
    end

    assign guestReject = newGuest;
`else
    logic unusedGuest;
    assign unusedGuest = bus.is_guest;
    assign guestReject = 1'b0;
`endif

    // An empty slot or a strictly lower score is where the new entry goes.
    assign hit = !slotValid[scanIdx] || (slotScore[scanIdx] < newScore);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state and handshake outputs.
    always_comb begin
        nextState = state;
        busyC     = (state != IDLE);
        doneC     = 1'b0;
        insertedC = 1'b0;
        insRankC  = '0;
        case (state)
            IDLE:  if (!bus.clear && bus.submit) nextState = CHECK;
            CHECK: nextState = (!isBcd({newId, newScore}) || guestReject) ? DONE : SCAN;
            SCAN: begin
                if (hit)                  nextState = (scanIdx == LAST) ? WRITE : SHIFT;
                else if (scanIdx == LAST) nextState = DONE;
            end
            SHIFT: if (shiftIdx == hitIdx + 1'b1) nextState = WRITE;
            WRITE: nextState = DONE;
            DONE: begin
                nextState = IDLE;
                doneC     = 1'b1;
                insertedC = insFlag;
                insRankC  = insFlag ? hitIdx : '0;
            end
            default: nextState = IDLE;
        endcase
    end

    // Table and working registers; the table only changes in IDLE (clear),
    // SHIFT and WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slotValid <= '0;
            slotId    <= '0;
            slotScore <= '0;
            newId     <= '0;
            newScore  <= '0;
            scanIdx   <= '0;
            shiftIdx  <= '0;
            hitIdx    <= '0;
            insFlag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        slotValid <= '0;
                    end else if (bus.submit) begin
                        newId    <= bus.sub_id;
                        newScore <= bus.sub_score;
                        hitIdx   <= '0;
                        insFlag  <= 1'b0;
                    end
                end
                CHECK: scanIdx <= '0;
                SCAN: begin
                    if (hit) begin
                        hitIdx   <= scanIdx;
                        shiftIdx <= LAST;
                    end else begin
                        scanIdx <= scanIdx + 1'b1;
                    end
                end
                SHIFT: begin
                    slotValid[shiftIdx] <= slotValid[shiftIdx - 1'b1];
                    slotId[shiftIdx]    <= slotId[shiftIdx - 1'b1];
                    slotScore[shiftIdx] <= slotScore[shiftIdx - 1'b1];
                    shiftIdx            <= shiftIdx - 1'b1;
                end
                WRITE: begin
                    slotValid[hitIdx] <= 1'b1;
                    slotId[hitIdx]    <= newId;
                    slotScore[hitIdx] <= newScore;
                    insFlag           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read view padded to a power of two so out-of-range ranks read as empty
    // without a compare; empty slots read as all-zero.
    logic [RD_DEPTH-1:0]           rdValid;
    logic [RD_DEPTH-1:0][ID_W-1:0] rdId;
    logic [RD_DEPTH-1:0][SC_W-1:0] rdScore;

    for (genvar g = 0; g < RD_DEPTH; g++) begin : gRd
        if (g < N_ENTRIES) begin : gSlot
            assign rdValid[g] = slotValid[g];
            assign rdId[g]    = slotValid[g] ? slotId[g]    : '0;
            assign rdScore[g] = slotValid[g] ? slotScore[g] : '0;
        end else begin : gPad
            assign rdValid[g] = 1'b0;
            assign rdId[g]    = '0;
            assign rdScore[g] = '0;
        end
    end

    logic            rankValidQ;
    logic [ID_W-1:0] rankIdQ;
    logic [SC_W-1:0] rankScoreQ;

    // Registered rank read for the display path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rankValidQ <= 1'b0;
            rankIdQ    <= '0;
            rankScoreQ <= '0;
        end else begin
            rankValidQ <= rdValid[bus.rank_sel];
            rankIdQ    <= rdId[bus.rank_sel];
            rankScoreQ <= rdScore[bus.rank_sel];
        end
    end

    assign bus.busy       = busyC;
    assign bus.done       = doneC;
    assign bus.inserted   = insertedC;
    assign bus.ins_rank   = insRankC;
    assign bus.rank_valid = rankValidQ;
    assign bus.rank_id    = rankIdQ;
    assign bus.rank_score = rankScoreQ;
endmodule

// File: tb/tb_score_leaderboard.sv
// Scoreboard bench for score_leaderboard (N_ENTRIES=8, 4 ID digits, 2 score digits).
// Submissions push the expected completion (inserted, rank, done edge) into a
// queue; a monitor pops and compares on each done pulse.
module tb_score_leaderboard;
    logic clk;
    logic rst;
    int   cyc;
    int   nChecks;
    int   nPass;

    score_leaderboard_if #(.N_ENTRIES(8), .ID_DIGITS(4), .SCORE_DIGITS(2)) bus ();

    score_leaderboard #(.N_ENTRIES(8), .ID_DIGITS(4), .SCORE_DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       ins;
        logic [2:0] rank;
        int         doneCyc;
    } exp_t;

    exp_t expQ[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && bus.done) begin
            if (expQ.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk("inserted", 32'(bus.inserted), 32'(e.ins));
                chk("ins_rank", 32'(bus.ins_rank), 32'(e.rank));
                chk("done_edge", 32'(cyc), 32'(e.doneCyc));
            end
        end
    end

    // Issue one submission; lat is the edge count E0->done (done at E<lat>).
    task automatic doSubmit(input logic [15:0] id, input logic [7:0] sc, input logic guest,
                            input logic expIns, input logic [2:0] expRank, input int lat);
        exp_t e;
        bit   ok;
        @(negedge clk);
        bus.submit    = 1'b1;
        bus.sub_id    = id;
        bus.sub_score = sc;
        bus.is_guest  = guest;
        e.ins     = expIns;
        e.rank    = expRank;
        e.doneCyc = cyc + 1 + lat;
        expQ.push_back(e);
        @(negedge clk);
        bus.submit   = 1'b0;
        bus.is_guest = 1'b0;
        chk("busy_after_E0", 32'(bus.busy), 32'd1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic readRank(input int r, input logic v, input logic [15:0] id, input logic [7:0] sc);
        @(negedge clk);
        bus.rank_sel = 3'(r);
        @(negedge clk);
        chk($sformatf("rank%0d_valid", r), 32'(bus.rank_valid), 32'(v));
        chk($sformatf("rank%0d_id", r), 32'(bus.rank_id), 32'(id));
        chk($sformatf("rank%0d_score", r), 32'(bus.rank_score), 32'(sc));
    endtask

    task automatic doClear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_inserted"}, 32'(bus.inserted), 32'd0);
        chk({tag, "_ins_rank"}, 32'(bus.ins_rank), 32'd0);
        chk({tag, "_rank_valid"}, 32'(bus.rank_valid), 32'd0);
        chk({tag, "_rank_id"}, 32'(bus.rank_id), 32'd0);
        chk({tag, "_rank_score"}, 32'(bus.rank_score), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        cyc           = 0;
        nChecks       = 0;
        nPass         = 0;
        rst           = 1'b0;
        bus.submit    = 1'b0;
        bus.is_guest  = 1'b0;
        bus.sub_id    = '0;
        bus.sub_score = '0;
        bus.clear     = 1'b0;
        bus.rank_sel  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chkAllZero("reset");
        rst = 1'b1;

        // First entry into an empty table.
        doSubmit(16'h1234, 8'h42, 1'b0, 1'b1, 3'd0, 10);
        readRank(0, 1'b1, 16'h1234, 8'h42);
        readRank(1, 1'b0, 16'h0000, 8'h00);

        // Rank ordering with a tie.
        doClear();
        doSubmit(16'h0001, 8'h50, 1'b0, 1'b1, 3'd0, 10);
        doSubmit(16'h0002, 8'h70, 1'b0, 1'b1, 3'd0, 10);
        doSubmit(16'h0003, 8'h60, 1'b0, 1'b1, 3'd1, 10);
        doSubmit(16'h0004, 8'h70, 1'b0, 1'b1, 3'd1, 10);
        readRank(0, 1'b1, 16'h0002, 8'h70);
        readRank(1, 1'b1, 16'h0004, 8'h70);
        readRank(2, 1'b1, 16'h0003, 8'h60);
        readRank(3, 1'b1, 16'h0001, 8'h50);
        readRank(4, 1'b0, 16'h0000, 8'h00);

        // Full table of equal scores; ties land at the end.
        doClear();
        for (int i = 0; i < 8; i++) doSubmit(16'h0100 + 16'(i), 8'h90, 1'b0, 1'b1, 3'(i), 10);
        doSubmit(16'h9999, 8'h89, 1'b0, 1'b0, 3'd0, 9);
        readRank(7, 1'b1, 16'h0107, 8'h90);
        doSubmit(16'h0500, 8'h95, 1'b0, 1'b1, 3'd0, 10);
        readRank(0, 1'b1, 16'h0500, 8'h95);
        readRank(1, 1'b1, 16'h0100, 8'h90);
        readRank(7, 1'b1, 16'h0106, 8'h90);

        // Non-BCD submissions are rejected straight out of CHECK.
        doSubmit(16'h0600, 8'h4A, 1'b0, 1'b0, 3'd0, 1);
        doSubmit(16'h12F4, 8'h10, 1'b0, 1'b0, 3'd0, 1);
        readRank(0, 1'b1, 16'h0500, 8'h95);

        // Clear wins over a simultaneous submit.
        @(negedge clk);
        bus.submit    = 1'b1;
        bus.clear     = 1'b1;
        bus.sub_id    = 16'h0700;
        bus.sub_score = 8'h99;
        @(negedge clk);
        bus.submit = 1'b0;
        bus.clear  = 1'b0;
        chk("clear_submit_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("clear_submit_busy2", 32'(bus.busy), 32'd0);
        readRank(0, 1'b0, 16'h0000, 8'h00);
        readRank(7, 1'b0, 16'h0000, 8'h00);

        // Guest submission.
`ifdef SCORE_LEADERBOARD_GUEST_FILTER_EN
        doSubmit(16'h0777, 8'h99, 1'b1, 1'b0, 3'd0, 1);
        readRank(0, 1'b0, 16'h0000, 8'h00);
`else
        doSubmit(16'h0777, 8'h99, 1'b1, 1'b1, 3'd0, 10);
        readRank(0, 1'b1, 16'h0777, 8'h99);
`endif

        // Reset while shifting: no completion is expected.
        @(negedge clk);
        bus.submit    = 1'b1;
        bus.sub_id    = 16'h0888;
        bus.sub_score = 8'h98;
        @(posedge clk);
        #1 bus.submit = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1 chkAllZero("midop_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 8; r++) readRank(r, 1'b0, 16'h0000, 8'h00);
        repeat (15) @(negedge clk);
        chk("pending_expectations", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
